pbvi_backup_scan: RTL
=====================

Name: pbvi_backup_scan

Overview:
- Parametrised successor to the fixed-size step-2 backup stage of the PBVI pipeline.
- For each belief point and action, it picks, per observation, the alpha vector with the largest dot product against the belief. It then forms the backed-up vector: reward plus the sum of the selected alphas.
- Alphas are scanned serially, one per cycle, with all action/observation pairs in parallel. Beliefs are processed in sequence.
- Supports a runtime count of active alphas and a start/busy/done handshake toward step 3.

Parameters:
- DATA_W, 16, width of reward, alpha, belief and output elements (unsigned).
- NUM_STATES, 2, states per vector (S).
- NUM_ACTIONS, 3, actions (A).
- NUM_OBS, 2, observations (O).
- NUM_ALPHA, 16, maximum alpha vectors per (action, observation) (N).
- NUM_BELIEF, 16, belief points (B).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a backup pass; sampled only in IDLE
- num_alpha  in  $clog2(NUM_ALPHA+1)  active alpha count n; 0 is treated as 1; values above N are clamped to N
- gamma_ao_alpha  in  DATA_W x [A][O][N][S]  intermediate alpha vectors
- gamma_reward  in  DATA_W x [A][S]  reward vectors
- point_belief  in  DATA_W x [B][S]  belief points
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse when all outputs are final (drives en_step3)
- gamma_action_belief  out  DATA_W x [A][B][S]  backed-up vectors

Behaviour:
- Reset is asynchronous, active-low; clock is clk. Under reset: state=IDLE, busy=0, done=0, all gamma_action_belief=0, and all counters, max and index registers cleared.
- FSM states: IDLE, SCAN, ACCUM, FIN.
  - IDLE: if start=1, latch n_eff, set b=0, j=0, and go to SCAN.
  - SCAN, one cycle per j:
    - For every (a,o), compute dot = sum over s of gamma_ao_alpha[a][o][j][s] * point_belief[b][s], at full width 2*DATA_W+$clog2(S).
    - If j==0, or dot is strictly greater than max[a][o], update max[a][o]=dot and idx[a][o]=j. Ties therefore keep the lowest index.
    - j increments; after j==n_eff-1, go to ACCUM.
  - ACCUM, one cycle: for every a and s, write gamma_action_belief[a][b][s] = gamma_reward[a][s] + sum over o of gamma_ao_alpha[a][o][idx[a][o]][s].
    - The sum is taken modulo 2^DATA_W unless the saturation option is enabled.
    - If b==B-1, go to FIN; otherwise b++, j=0, and return to SCAN.
  - FIN: done=1 for exactly one cycle, then return to IDLE.
- busy=1 in SCAN, ACCUM and FIN; busy=0 in IDLE.
- Latency: if start is sampled at edge k, done is high in the cycle after edge k + B*(n_eff+1) + 1.
- Output rows update progressively; rows not yet written keep the previous pass's values.
- Inputs must be held stable while busy=1. start while busy is ignored; no queueing.
- start and FIN coincide: the start is ignored. The next start is accepted in IDLE.
- Reset mid-pass: the pass is abandoned, outputs clear to 0, and no done pulse is issued.
- num_alpha is sampled only at start; changes during busy have no effect.

Optional Feature:
- Macro: PBVI_BACKUP_SAT_EN.
- Defined: the ACCUM sum is computed at DATA_W+$clog2(O+1) bits and saturated to 2^DATA_W-1.
- Undefined: the sum wraps modulo 2^DATA_W.
- Scan behaviour and timing are identical in both cases.

Test Plan:
- Tie-break: all gamma_ao_alpha=1, reward=5, n=16, all beliefs=(1,1) -> idx=0 everywhere; every output=7; done at start+16*17+1 cycles.
- Distinct maxima: gamma_ao_alpha[a][o][j]=(j,15-j), reward=0, n=16.
  - Belief (1,0) -> output (30,0).
  - Belief (0,1) -> output (0,30).
- Runtime count: same data as the previous test, n=4, belief (1,0) -> output (6,24); done at start+16*5+1; num_alpha=0 behaves as n=1 and gives output (0,30).
- Overflow: reward=0xFFF0; selected alphas for o=0 and o=1 are both 0x0010 in s0 -> s0=0x0010 without the macro, 0xFFFF with PBVI_BACKUP_SAT_EN.
- Handshake: start pulsed again mid-pass -> no restart, single done pulse. rst_n low mid-pass -> outputs 0, busy=0, no done; a new start after release completes normally.

Source files
------------

// File: rtl/pbvi_backup_scan.sv
// pbvi_backup_scan: PBVI step-2 backup; serial alpha scan with per-(a,o) argmax, then reward + selected alphas.
// Optional macro PBVI_BACKUP_SAT_EN saturates the accumulated sums instead of wrapping.
module pbvi_backup_scan #(
  parameter int DATA_W     = 16,
  parameter int NUM_STATES = 2,
  parameter int NUM_ACTIONS = 3,
  parameter int NUM_OBS    = 2,
  parameter int NUM_ALPHA  = 16,
  parameter int NUM_BELIEF = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [$clog2(NUM_ALPHA+1)-1:0]     num_alpha,
  input  logic [DATA_W-1:0]                  gamma_ao_alpha [NUM_ACTIONS][NUM_OBS][NUM_ALPHA][NUM_STATES],
  input  logic [DATA_W-1:0]                  gamma_reward [NUM_ACTIONS][NUM_STATES],
  input  logic [DATA_W-1:0]                  point_belief [NUM_BELIEF][NUM_STATES],
  output logic                               busy,
  output logic                               done,
  output logic [DATA_W-1:0]                  gamma_action_belief [NUM_ACTIONS][NUM_BELIEF][NUM_STATES]
);
  localparam int NW = $clog2(NUM_ALPHA+1);
  localparam int JW = NUM_ALPHA > 1 ? $clog2(NUM_ALPHA) : 1;
  localparam int BW = NUM_BELIEF > 1 ? $clog2(NUM_BELIEF) : 1;
  localparam int DW = 2*DATA_W + $clog2(NUM_STATES);
`ifdef PBVI_BACKUP_SAT_EN
  localparam int SW = DATA_W + $clog2(NUM_OBS+1);
`else
  localparam int SW = DATA_W;
`endif
  typedef enum logic [1:0] {IDLE, SCAN, ACCUM, FIN} state_t;
  state_t r_state, w_next;
  logic [JW-1:0] r_j, r_last;
  logic [BW-1:0] r_b;
  logic r_done;
  logic [DW-1:0] r_max [NUM_ACTIONS][NUM_OBS];
  logic [JW-1:0] r_idx [NUM_ACTIONS][NUM_OBS];
  logic [DW-1:0] w_dot [NUM_ACTIONS][NUM_OBS];
  logic [SW-1:0] w_sum [NUM_ACTIONS][NUM_STATES];
  logic [DATA_W-1:0] w_acc [NUM_ACTIONS][NUM_STATES];
  logic [NW-1:0] w_neff;
  logic w_last_b;
  assign w_neff = num_alpha == '0 ? NW'(1) : num_alpha > NW'(NUM_ALPHA) ? NW'(NUM_ALPHA) : num_alpha;
  assign w_last_b = r_b == BW'(NUM_BELIEF-1);
  assign busy = r_state != IDLE;
  assign done = r_done;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? SCAN : IDLE;
      SCAN:    w_next = r_j == r_last ? ACCUM : SCAN;
      ACCUM:   w_next = w_last_b ? FIN : SCAN;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    for (int a = 0; a < NUM_ACTIONS; a++)
      for (int o = 0; o < NUM_OBS; o++) begin
        w_dot[a][o] = '0;
        for (int s = 0; s < NUM_STATES; s++)
          w_dot[a][o] += DW'(gamma_ao_alpha[a][o][r_j][s]) * DW'(point_belief[r_b][s]);
      end
    for (int a = 0; a < NUM_ACTIONS; a++)
      for (int s = 0; s < NUM_STATES; s++) begin
        w_sum[a][s] = SW'(gamma_reward[a][s]);
        for (int o = 0; o < NUM_OBS; o++)
          w_sum[a][s] += SW'(gamma_ao_alpha[a][o][r_idx[a][o]][s]);
`ifdef PBVI_BACKUP_SAT_EN
        w_acc[a][s] = w_sum[a][s] > SW'({DATA_W{1'b1}}) ? {DATA_W{1'b1}} : w_sum[a][s][DATA_W-1:0];
`else
        w_acc[a][s] = w_sum[a][s];
`endif
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_j    <= '0;
      r_last <= '0;
      r_b    <= '0;
      r_done <= 1'b0;
      for (int a = 0; a < NUM_ACTIONS; a++) begin
        for (int o = 0; o < NUM_OBS; o++) begin
          r_max[a][o] <= '0;
          r_idx[a][o] <= '0;
        end
        for (int b = 0; b < NUM_BELIEF; b++)
          for (int s = 0; s < NUM_STATES; s++)
            gamma_action_belief[a][b][s] <= '0;
      end
    end else begin
      r_done <= r_state == FIN;
      if (r_state == IDLE && start) begin
        r_last <= JW'(w_neff - 1'b1);
        r_b    <= '0;
        r_j    <= '0;
      end
      if (r_state == SCAN) begin
        // strict compare keeps the lowest index on ties
        for (int a = 0; a < NUM_ACTIONS; a++)
          for (int o = 0; o < NUM_OBS; o++)
            if (r_j == '0 || w_dot[a][o] > r_max[a][o]) begin
              r_max[a][o] <= w_dot[a][o];
              r_idx[a][o] <= r_j;
            end
        r_j <= r_j + 1'b1;
      end
      if (r_state == ACCUM) begin
        for (int a = 0; a < NUM_ACTIONS; a++)
          for (int s = 0; s < NUM_STATES; s++)
            gamma_action_belief[a][r_b][s] <= w_acc[a][s];
        r_j <= '0;
        if (!w_last_b) r_b <= r_b + 1'b1;
      end
    end
endmodule
